memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 8, memory address width.
- DATA_WIDTH, 16, memory word width.

REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- fetchReq  in  1  instruction-fetch read request.
- fetchAddress  in  ADDR_WIDTH  fetch address.
- fetchReady  out  1  one-cycle pulse; fetchData valid.
- fetchData  out  DATA_WIDTH  fetched word; held until the next fetch completes.
- dataReq  in  1  load/store request.
- dataWrite  in  1  1 = store, 0 = load.
- dataAddress  in  ADDR_WIDTH  load/store address.
- dataWriteData  in  DATA_WIDTH  store data.
- dataReady  out  1  one-cycle pulse; load/store complete.
- dataReadData  out  DATA_WIDTH  loaded word; held until the next load completes.
- memEnable  out  1  to memory enable.
- memWriteEnable  out  1  to memory writeEnable.
- memAddress  out  ADDR_WIDTH  to memory address.
- memWriteData  out  DATA_WIDTH  to memory writeData.
- memReadData  in  DATA_WIDTH  from memory readData; valid after the posedge that samples an enabled read.
- busy  out  1  high in ISSUE and CAPTURE.

Function
REQ-003 The FSM SHALL have three states: IDLE, ISSUE and CAPTURE.
REQ-004 All outputs SHALL be registered.
REQ-005 Requests SHALL be sampled only in IDLE.
REQ-006 Requesters SHALL hold req, address, dataWrite and dataWriteData stable until their ready pulse.
REQ-007 IDLE with no request SHALL remain in IDLE, with memEnable=0 and memWriteEnable=0.
REQ-008 IDLE with at least one request SHALL, at edge E1, perform all of the following:
- select a winner;
- go to ISSUE;
- drive memEnable=1 and memAddress to the winner's address;
- drive memWriteEnable=1 and memWriteData=dataWriteData only for a data store; otherwise memWriteEnable=0.
REQ-009 ISSUE SHALL, at E2 (the posedge where memory performs the access), go to CAPTURE and drive memEnable=0 and memWriteEnable=0.
REQ-010 CAPTURE SHALL, at E3, go to IDLE and assert the winner's ready for exactly one cycle.
REQ-011 At E3, fetchData SHALL load memReadData for a fetch, and dataReadData SHALL load memReadData for a load; dataReadData SHALL be unchanged on a store.
REQ-012 Latency SHALL be 3 cycles from the sampling edge to the ready pulse, for both reads and writes; maximum throughput SHALL be one access per 3 cycles.
REQ-013 A req still high at E4 (in the ready cycle) SHALL be treated as a new request; requesters drop req in the ready cycle to avoid a repeat.
REQ-014 When only one requester is active, it SHALL be granted.
REQ-015 When both requesters are active, the requester not granted last SHALL win (round-robin via a 1-bit lastGrant updated at each E1).
REQ-016 The losing request SHALL stay pending and SHALL be granted at the next IDLE sample, giving no starvation; worst-case wait is 6 cycles.
REQ-017 Simultaneous request arrival during ISSUE or CAPTURE SHALL be ignored until IDLE.
REQ-018 fetchReady and dataReady SHALL never be high in the same cycle.
REQ-019 memEnable SHALL be high for exactly one cycle per grant.
REQ-020 dataWrite SHALL be ignored when dataReq=0.

Reset
REQ-021 reset high at a posedge SHALL force state=IDLE, lastGrant=data and busy=0.
REQ-022 reset high at a posedge SHALL force memEnable, memWriteEnable, fetchReady and dataReady to 0.
REQ-023 reset high at a posedge SHALL force memAddress, memWriteData, fetchData and dataReadData to 0.
REQ-024 Reset in ISSUE or CAPTURE SHALL abandon the access with no ready pulse; a store already sampled by memory at E2 stays committed.
REQ-025 Reset SHALL take priority over all requests in the same cycle.

Verification
REQ-026 The bench SHALL cover at least these directed scenarios:
- Single fetch: fetchReq=1, fetchAddress=0x03, mem[0x03]=0x1234 -> memEnable=1 for one cycle with memAddress=0x03; fetchReady pulses 3 cycles after sample with fetchData=0x1234.
- Store then load: dataReq=1, dataWrite=1, addr 0x0F, data 0xFA2D -> memWriteEnable=1 for one cycle, dataReady pulse, dataReadData unchanged; then load 0x0F -> dataReadData=0xFA2D.
- Contention after reset: fetchReq=dataReq=1 held -> order fetch, data, fetch, data; ready pulses 3 cycles apart, never coincident.
- Back-to-back: fetchReq held high across the ready cycle with addresses 0x00..0x04 -> five fetches, one per 3 cycles, data matching memory.
- Reset mid-access: reset asserted in CAPTURE of load 0x0C -> no dataReady, all outputs 0 next cycle, next request served normally.
- Idle: no requests for 10 cycles -> memEnable=0, busy=0 throughout.

Source files
------------

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port synchronous memory between an
// instruction-fetch port and a load/store port. Each access takes three
// cycles (IDLE -> ISSUE -> CAPTURE). On contention the two requesters
// alternate, so neither can be starved.
module memory_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    // instruction-fetch port
    input  logic                  fetchReq,
    input  logic [ADDR_WIDTH-1:0] fetchAddress,
    output logic                  fetchReady,
    output logic [DATA_WIDTH-1:0] fetchData,
    // load/store port
    input  logic                  dataReq,
    input  logic                  dataWrite,
    input  logic [ADDR_WIDTH-1:0] dataAddress,
    input  logic [DATA_WIDTH-1:0] dataWriteData,
    output logic                  dataReady,
    output logic [DATA_WIDTH-1:0] dataReadData,
    // memory side
    output logic                  memEnable,
    output logic                  memWriteEnable,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    input  logic [DATA_WIDTH-1:0] memReadData,
    // status
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    // Requester identifiers, used for both the current grant and lastGrant.
    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;

    state_t state;
    logic   lastGrant;    // requester granted most recently
    logic   grantData;    // current access belongs to the data port
    logic   grantWrite;   // current access is a store
    logic   anyReq;
    logic   pickData;

    // Winner selection: a lone requester always wins; on contention the
    // requester that was not granted last wins. dataWrite is ignored here,
    // so it has no effect while dataReq is low.
    always_comb begin
        anyReq   = fetchReq | dataReq;
        pickData = dataReq & (~fetchReq | (lastGrant == GRANT_FETCH));
    end

    // Access sequencer: every output is a register updated here, and
    // reset takes priority over any request seen in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            lastGrant      <= GRANT_DATA;
            grantData      <= GRANT_FETCH;
            grantWrite     <= 1'b0;
            busy           <= 1'b0;
            memEnable      <= 1'b0;
            memWriteEnable <= 1'b0;
            memAddress     <= '0;
            memWriteData   <= '0;
            fetchReady     <= 1'b0;
            fetchData      <= '0;
            dataReady      <= 1'b0;
            dataReadData   <= '0;
        end else begin
            // Ready outputs are single-cycle pulses.
            fetchReady <= 1'b0;
            dataReady  <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        state      <= ISSUE;
                        busy       <= 1'b1;
                        memEnable  <= 1'b1;
                        grantData  <= pickData;
                        lastGrant  <= pickData;
                        if (pickData) begin
                            memAddress     <= dataAddress;
                            memWriteEnable <= dataWrite;
                            grantWrite     <= dataWrite;
                            if (dataWrite) begin
                                memWriteData <= dataWriteData;
                            end
                        end else begin
                            memAddress     <= fetchAddress;
                            memWriteEnable <= 1'b0;
                            grantWrite     <= 1'b0;
                        end
                    end else begin
                        memEnable      <= 1'b0;
                        memWriteEnable <= 1'b0;
                    end
                end
                ISSUE: begin
                    // Memory performs the access on this edge; the enable
                    // therefore lasts exactly one cycle per grant.
                    state          <= CAPTURE;
                    memEnable      <= 1'b0;
                    memWriteEnable <= 1'b0;
                end
                CAPTURE: begin
                    // Read data became valid after the previous edge.
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (grantData == GRANT_DATA) begin
                        dataReady <= 1'b1;
                        if (!grantWrite) begin
                            dataReadData <= memReadData;
                        end
                    end else begin
                        fetchReady <= 1'b1;
                        fetchData  <= memReadData;
                    end
                end
                default: begin
                    state          <= IDLE;
                    busy           <= 1'b0;
                    memEnable      <= 1'b0;
                    memWriteEnable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed bench for memory_arbiter with a behavioural
// synchronous memory. Single-requester accesses come from a vector table;
// contention, back-to-back, mid-access reset and idle are hand sequences.
module tb_memory_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetchReq;
    logic [7:0]  fetchAddress;
    logic        fetchReady;
    logic [15:0] fetchData;
    logic        dataReq;
    logic        dataWrite;
    logic [7:0]  dataAddress;
    logic [15:0] dataWriteData;
    logic        dataReady;
    logic [15:0] dataReadData;
    logic        memEnable;
    logic        memWriteEnable;
    logic [7:0]  memAddress;
    logic [15:0] memWriteData;
    logic [15:0] memReadData;
    logic        busy;

    int total = 0;
    int bad   = 0;

    memory_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clock(clock), .reset(reset),
        .fetchReq(fetchReq), .fetchAddress(fetchAddress),
        .fetchReady(fetchReady), .fetchData(fetchData),
        .dataReq(dataReq), .dataWrite(dataWrite), .dataAddress(dataAddress),
        .dataWriteData(dataWriteData), .dataReady(dataReady),
        .dataReadData(dataReadData),
        .memEnable(memEnable), .memWriteEnable(memWriteEnable),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memReadData(memReadData), .busy(busy)
    );

    always #5 clock = ~clock;

    // Behavioural memory: contents A500|addr, except 0x03=1234, 0x0C=BEEF.
    logic [15:0] mem [256];
    logic        memLoaded = 1'b0;
    always @(posedge clock) begin
        if (!memLoaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA500 | 16'(i);
            mem[3]    <= 16'h1234;
            mem[12]   <= 16'hBEEF;
            memLoaded <= 1'b1;
        end else if (memEnable) begin
            if (memWriteEnable) mem[memAddress] <= memWriteData;
            else                memReadData     <= mem[memAddress];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    localparam logic [1:0] K_FETCH = 2'd0;
    localparam logic [1:0] K_LOAD  = 2'd1;
    localparam logic [1:0] K_STORE = 2'd2;

    typedef struct {
        logic [1:0]  kind;
        logic        stray;   // dataWrite high on a fetch (dataReq low)
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;     // expected destination register after access
    } vec_t;

    logic [15:0] expFetch;
    logic [15:0] expDread;

    // One single-requester access, starting and ending at a negedge.
    task automatic run_access(input string tag, input vec_t v);
        logic isFetch;
        logic isStore;
        isFetch = (v.kind == K_FETCH);
        isStore = (v.kind == K_STORE);
        if (isFetch) begin
            fetchReq = 1'b1; fetchAddress = v.addr;
            dataWrite = v.stray; dataWriteData = v.wdata;
        end else begin
            dataReq = 1'b1; dataAddress = v.addr;
            dataWrite = isStore; dataWriteData = v.wdata;
        end
        @(negedge clock);  // after E1
        check({tag, " E1 memEnable"}, 32'(memEnable), 32'd1);
        check({tag, " E1 memAddress"}, 32'(memAddress), 32'(v.addr));
        check({tag, " E1 memWriteEnable"}, 32'(memWriteEnable), 32'(isStore));
        if (isStore) check({tag, " E1 memWriteData"}, 32'(memWriteData), 32'(v.wdata));
        check({tag, " E1 busy"}, 32'(busy), 32'd1);
        @(negedge clock);  // after E2
        check({tag, " E2 memEnable/we"}, {memEnable, memWriteEnable}, 32'd0);
        check({tag, " E2 ready"}, {fetchReady, dataReady}, 32'd0);
        check({tag, " E2 busy"}, 32'(busy), 32'd1);
        @(negedge clock);  // after E3: ready cycle
        if (isFetch) expFetch = v.exp; else expDread = v.exp;
        check({tag, " E3 fetchReady"}, 32'(fetchReady), 32'(isFetch));
        check({tag, " E3 dataReady"}, 32'(dataReady), 32'(!isFetch));
        check({tag, " E3 fetchData"}, 32'(fetchData), 32'(expFetch));
        check({tag, " E3 dataReadData"}, 32'(dataReadData), 32'(expDread));
        check({tag, " E3 busy"}, 32'(busy), 32'd0);
        fetchReq = 1'b0; dataReq = 1'b0; dataWrite = 1'b0;
        @(negedge clock);  // after E4: ready must be gone, no repeat
        check({tag, " E4 ready"}, {fetchReady, dataReady}, 32'd0);
        check({tag, " E4 memEnable"}, 32'(memEnable), 32'd0);
        check({tag, " E4 busy"}, 32'(busy), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " memEnable"}, 32'(memEnable), 32'd0);
        check({tag, " memWriteEnable"}, 32'(memWriteEnable), 32'd0);
        check({tag, " memAddress"}, 32'(memAddress), 32'd0);
        check({tag, " memWriteData"}, 32'(memWriteData), 32'd0);
        check({tag, " fetchReady"}, 32'(fetchReady), 32'd0);
        check({tag, " dataReady"}, 32'(dataReady), 32'd0);
        check({tag, " fetchData"}, 32'(fetchData), 32'd0);
        check({tag, " dataReadData"}, 32'(dataReadData), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    vec_t        vecs [12];
    logic [15:0] bbExp [5];

    initial begin
        vecs[0]  = '{K_FETCH, 1'b0, 8'h03, 16'h0000, 16'h1234};
        vecs[1]  = '{K_STORE, 1'b0, 8'h0F, 16'hFA2D, 16'h0000};
        vecs[2]  = '{K_LOAD,  1'b0, 8'h0F, 16'h0000, 16'hFA2D};
        vecs[3]  = '{K_FETCH, 1'b0, 8'h0F, 16'h0000, 16'hFA2D};
        vecs[4]  = '{K_STORE, 1'b0, 8'h20, 16'h5A5A, 16'hFA2D};
        vecs[5]  = '{K_LOAD,  1'b0, 8'h20, 16'h0000, 16'h5A5A};
        vecs[6]  = '{K_FETCH, 1'b1, 8'hFF, 16'hDEAD, 16'hA5FF};
        vecs[7]  = '{K_LOAD,  1'b0, 8'hFF, 16'h0000, 16'hA5FF};
        vecs[8]  = '{K_STORE, 1'b0, 8'hFF, 16'hFFFF, 16'hA5FF};
        vecs[9]  = '{K_LOAD,  1'b0, 8'hFF, 16'h0000, 16'hFFFF};
        vecs[10] = '{K_FETCH, 1'b0, 8'h00, 16'h0000, 16'hA500};
        vecs[11] = '{K_LOAD,  1'b0, 8'h07, 16'h0000, 16'hA507};
        bbExp = '{16'hA500, 16'hA501, 16'hA502, 16'h1234, 16'hA504};

        reset = 1'b1; fetchReq = 1'b0; fetchAddress = '0; dataReq = 1'b0;
        dataWrite = 1'b0; dataAddress = '0; dataWriteData = '0;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;
        expFetch = '0; expDread = '0;
        @(negedge clock);

        // Single-requester vectors
        for (int i = 0; i < 12; i++) run_access($sformatf("vec%0d", i), vecs[i]);

        // Contention right after reset: fetch, data, fetch, data
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        fetchReq = 1'b1; fetchAddress = 8'h01;
        dataReq = 1'b1; dataAddress = 8'h02; dataWrite = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            logic rdyCyc;
            logic fetchTurn;
            @(negedge clock);
            rdyCyc    = (k % 3 == 0);
            fetchTurn = ((k / 3) % 2 == 1);
            check($sformatf("cont%0d memEnable", k), 32'(memEnable), 32'(k % 3 == 1));
            if (k % 3 == 1)
                check($sformatf("cont%0d memAddress", k), 32'(memAddress),
                      ((k / 3) % 2 == 0) ? 32'h01 : 32'h02);
            check($sformatf("cont%0d fetchReady", k), 32'(fetchReady), 32'(rdyCyc && fetchTurn));
            check($sformatf("cont%0d dataReady", k), 32'(dataReady), 32'(rdyCyc && !fetchTurn));
            if (rdyCyc && fetchTurn)
                check($sformatf("cont%0d fetchData", k), 32'(fetchData), 32'hA501);
            if (rdyCyc && !fetchTurn)
                check($sformatf("cont%0d dataReadData", k), 32'(dataReadData), 32'hA502);
        end
        fetchReq = 1'b0; dataReq = 1'b0;
        @(negedge clock);
        check("cont idle busy", 32'(busy), 32'd0);
        check("cont idle memEnable", 32'(memEnable), 32'd0);

        // Back-to-back fetches with req held through the ready cycle
        fetchReq = 1'b1; fetchAddress = 8'h00;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            if (k % 3 == 1) begin
                check($sformatf("b2b%0d memEnable", k), 32'(memEnable), 32'd1);
                check($sformatf("b2b%0d memAddress", k), 32'(memAddress), 32'((k - 1) / 3));
            end
            check($sformatf("b2b%0d fetchReady", k), 32'(fetchReady), 32'(k % 3 == 0));
            if (k % 3 == 0) begin
                check($sformatf("b2b%0d fetchData", k), 32'(fetchData), 32'(bbExp[k / 3 - 1]));
                fetchAddress = 8'(k / 3);
                if (k == 15) fetchReq = 1'b0;
            end
        end
        @(negedge clock);
        check("b2b end fetchReady", 32'(fetchReady), 32'd0);
        check("b2b end memEnable", 32'(memEnable), 32'd0);

        // Reset during CAPTURE of a load abandons it
        dataReq = 1'b1; dataWrite = 1'b0; dataAddress = 8'h0C;
        @(negedge clock);
        check("rstmid E1 memEnable", 32'(memEnable), 32'd1);
        @(negedge clock);
        check("rstmid E2 busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("rstmid");
        reset = 1'b0; dataReq = 1'b0;
        expFetch = '0; expDread = '0;
        @(negedge clock);
        check("rstmid after dataReady", 32'(dataReady), 32'd0);
        run_access("postrst", '{K_LOAD, 1'b0, 8'h0C, 16'h0000, 16'hBEEF});

        // Idle: nothing happens without requests
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check($sformatf("idle%0d memEnable", k), 32'(memEnable), 32'd0);
            check($sformatf("idle%0d busy", k), 32'(busy), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Ready pulses must never coincide.
    always @(negedge clock) begin
        if (reset === 1'b0 && fetchReady === 1'b1 && dataReady === 1'b1) begin
            total++;
            bad++;
            $display("FAIL readyOverlap: fetchReady=%0b dataReady=%0b, required not both 1",
                     fetchReady, dataReady);
        end
    end

    // Absolute time limit so the run always ends.
    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "timeout");
    end

endmodule
